// File: rtl/img_loader_if.sv
// Pixel-stream, image-memory write and engine handshake signals of img_loader.
// The slave modport is the loader side; the master modport is the upstream/engine side.
interface img_loader_if;
    logic        in_valid;
    logic [19:0] in_data;   // signed Q4.16 pixel
    logic        in_ready;
    logic        iwr;
    logic [11:0] iaddr_wr;
    logic [19:0] idata_wr;
    logic        ready;
    logic        busy;
    logic        frame_done;
    logic [19:0] checksum;

    modport master (
        output in_valid, in_data, busy,
        input  in_ready, iwr, iaddr_wr, idata_wr, ready, frame_done, checksum
    );

    modport slave (
        input  in_valid, in_data, busy,
        output in_ready, iwr, iaddr_wr, idata_wr, ready, frame_done, checksum
    );
endinterface

// File: rtl/img_loader.sv
// Loads one NPIX-pixel frame into image memory, then hands it to the convolution engine.
// Define CHECKSUM_EN to build the per-frame XOR checksum register; otherwise checksum is 0.
module img_loader #(
    parameter int unsigned NPIX = 4096
) (
    input logic         clk,
    input logic         reset,
    img_loader_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StHand, StWaitHi, StWaitLo} state_e;

    localparam logic [11:0] LastIdx = 12'(NPIX - 1);

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        ready_q, ready_d;
    logic        frame_done_q, frame_done_d;
    logic        iwr_q;
    logic [11:0] iaddr_q;
    logic [19:0] idata_q;
    logic        in_ready;
    logic        accept;
    logic        last_pix;

    // busy gates in_ready combinationally so a busy engine blocks accepts at once
    assign in_ready = in_ready_q & ~bus.busy;
    assign accept   = bus.in_valid & in_ready;
    assign last_pix = (cnt_q == LastIdx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = last_pix ? StHand : StLoad;
            StLoad:   if (accept && last_pix) state_d = StHand;
            StHand:   state_d = StWaitHi;
            StWaitHi: if (bus.busy) state_d = StWaitLo;
            StWaitLo: if (!bus.busy) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StHand:   ready_d = 1'b1;
            StWaitHi: if (bus.busy) ready_d = 1'b0;
            StWaitLo: if (!bus.busy) frame_done_d = 1'b1;
            default:  begin end
        endcase
        // Accepting resumes only after the frame_done cycle
        in_ready_d = ((state_d == StIdle) && !frame_done_d) || (state_d == StLoad);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = last_pix ? '0 : cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            iwr_q        <= 1'b0;
            iaddr_q      <= '0;
            idata_q      <= '0;
        end else begin
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            iwr_q        <= accept;
            if (accept) begin
                iaddr_q <= cnt_q;
                idata_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.iwr        = iwr_q;
    assign bus.iaddr_wr   = iaddr_q;
    assign bus.idata_wr   = idata_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = frame_done_q;

`ifdef CHECKSUM_EN
    logic [19:0] csum_q;

    // The first accept of a frame (counter at 0) restarts the running XOR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= (cnt_q == '0) ? bus.in_data : (csum_q ^ bus.in_data);
        end
    end

    assign bus.checksum = csum_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_img_loader.sv
// Directed self-checking bench for img_loader: ramp, toggled-valid and patterned frames,
// engine handshake, mid-frame reset and checksum.
module tb_img_loader;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    img_loader_if bus ();

    img_loader #(.NPIX(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef CHECKSUM_EN
    // 4095 pixels of 1 xor to 1, combined with 0F0F0
    localparam logic [19:0] ExpSum = 20'h0F0F1;
`else
    localparam logic [19:0] ExpSum = 20'h00000;
`endif

    // Write/frame_done monitor
    int          cyc        = 0;
    int          wr_total   = 0;
    int          seq_err    = 0;
    int          data_err   = 0;
    int          fd_cnt     = 0;
    logic [11:0] prev_addr  = 12'hFFF;
    logic [11:0] first_addr = 12'hFFF;
    bit          first_seen = 1'b0;
    bit          chk_ramp   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            prev_addr  <= 12'hFFF;
            first_seen <= 1'b0;
        end else begin
            if (bus.iwr) begin
                wr_total <= wr_total + 1;
                if (bus.iaddr_wr != prev_addr + 12'd1) seq_err <= seq_err + 1;
                if (chk_ramp && bus.idata_wr != {8'd0, bus.iaddr_wr}) data_err <= data_err + 1;
                if (!first_seen) begin
                    first_addr <= bus.iaddr_wr;
                    first_seen <= 1'b1;
                end
                prev_addr <= bus.iaddr_wr;
            end
            if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [19:0] pix(input int mode, input int idx);
        if (mode == 2) return (idx == 7) ? 20'h0F0F0 : 20'h00001;
        return 20'(idx);
    endfunction

    // mode 0 ramp, 1 ramp with valid toggling, 2 pattern; stop_at < 0 sends the full frame
    task automatic feed(input int n, input int mode, input int stop_at, output int start);
        int idx   = 0;
        int guard = 0;
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_data  = pix(mode, 0);
        start        = cyc;
        while (idx < n && idx != stop_at && guard < 3 * n + 16) begin
            acc = bus.in_valid && bus.in_ready;
            step();
            guard++;
            if (acc) idx++;
            if (mode == 1) bus.in_valid = ~bus.in_valid;
            bus.in_data = pix(mode, idx);
        end
        bus.in_valid = 1'b0;
        check("feed_count", idx, (stop_at >= 0) ? stop_at : n);
    endtask

    task automatic wait_ready(output int rc);
        int g = 0;
        while (!bus.ready && g < 20) begin
            step();
            g++;
        end
        rc = cyc;
        check("ready_seen", int'(bus.ready), 1);
    endtask

    task automatic handshake(input bit hold_valid);
        int wb;
        int fb;
        repeat (3) step();
        check("ready_hold", int'(bus.ready), 1);
        #1 bus.busy = 1'b1;
        #1 bus.busy = 1'b0;
        step();
        check("busy_glitch", int'(bus.ready), 1);
        bus.busy = 1'b1;
        if (hold_valid) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 20'h12345;
        end
        wb = wr_total;
        fb = fd_cnt;
        step();
        check("ready_drop", int'(bus.ready), 0);
        check("in_ready_busy", int'(bus.in_ready), 0);
        repeat (99) step();
        check("busy_no_done", fd_cnt, fb);
        bus.busy = 1'b0;
        step();
        check("frame_done", int'(bus.frame_done), 1);
        check("no_wr_wait", wr_total, wb);
        step();
        check("done_pulse", int'(bus.frame_done), 0);
        check("done_count", fd_cnt - fb, 1);
        if (hold_valid) begin
            check("hold_no_wr", int'(bus.iwr), 0);
            step();
            bus.in_valid = 1'b0;
            check("resume_wr", int'(bus.iwr), 1);
            check("resume_addr", int'(bus.iaddr_wr), 0);
            check("resume_data", int'(bus.idata_wr), 32'h12345);
        end
    endtask

    initial begin
        int start;
        int rc;
        int base;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.busy     = 1'b0;
        repeat (3) step();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_iwr", int'(bus.iwr), 0);
        check("rst_iaddr", int'(bus.iaddr_wr), 0);
        check("rst_idata", int'(bus.idata_wr), 0);
        check("rst_ready", int'(bus.ready), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_checksum", int'(bus.checksum), 0);

        reset = 1'b1;
        #1 check("rel_in_ready_low", int'(bus.in_ready), 0);
        step();
        check("rel_in_ready_high", int'(bus.in_ready), 1);

        // Engine still busy in IDLE: nothing may be accepted
        bus.busy     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 20'h00005;
        repeat (3) step();
        check("idle_busy_in_ready", int'(bus.in_ready), 0);
        check("idle_busy_no_wr", wr_total, 0);
        bus.busy     = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("idle_release", int'(bus.in_ready), 1);

        // Ramp frame, valid every cycle
        base = wr_total;
        feed(4096, 0, -1, start);
        wait_ready(rc);
        check("ramp_ready_cyc", rc - start, 4097);
        check("ramp_writes", wr_total - base, 4096);
        check("ramp_last_addr", int'(prev_addr), 4095);
        check("ramp_seq", seq_err, 0);
        check("ramp_data", data_err, 0);
        handshake(1'b0);

        // Valid toggling every cycle
        base = wr_total;
        feed(4096, 1, -1, start);
        wait_ready(rc);
        check("tog_ready_cyc", rc - start, 8192);
        check("tog_writes", wr_total - base, 4096);
        check("tog_seq", seq_err, 0);
        check("tog_data", data_err, 0);
        handshake(1'b0);

        // Reset part-way through a frame
        chk_ramp = 1'b0;
        feed(4096, 2, 2000, start);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        check("mid_rst_iwr", int'(bus.iwr), 0);
        check("mid_rst_iaddr", int'(bus.iaddr_wr), 0);
        step();
        reset = 1'b1;
        step();
        check("mid_rel_in_ready", int'(bus.in_ready), 1);

        base = wr_total;
        feed(4096, 2, -1, start);
        wait_ready(rc);
        check("fresh_first_addr", int'(first_addr), 0);
        check("fresh_writes", wr_total - base, 4096);
        check("fresh_seq", seq_err, 0);
        check("fresh_checksum", int'(bus.checksum), int'(ExpSum));
        handshake(1'b0);
        check("checksum_held", int'(bus.checksum), int'(ExpSum));

        // Identical second frame, then valid held through the wait states
        base = wr_total;
        feed(4096, 2, -1, start);
        wait_ready(rc);
        check("second_writes", wr_total - base, 4096);
        check("second_checksum", int'(bus.checksum), int'(ExpSum));
        handshake(1'b1);
        check("final_seq", seq_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
